seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 142 ++++++++++++++
 tb/tb_seq_alu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops and a WIDTH-cycle shift-add multiplier.
// Results are held in an output register until the consumer takes them with Out_Ready.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [2:0]       Fn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Out,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [2:0]       NZP,
  output logic             C,
  output logic             V
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_n;
  logic [WIDTH-1:0] mcand, mcand_n, mplier, mplier_n, acc, acc_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [WIDTH-1:0] out_n;
  logic           valid_n, c_n, v_n;
  logic [2:0]     nzp_n;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             accept;

  assign In_Ready = Reset_n & (state == IDLE) & (~Out_Valid | Out_Ready);
  assign accept   = In_Valid & In_Ready;
  assign sum      = {1'b0, A} + {1'b0, B};
  assign diff     = A - B;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (Fn)
      3'b000: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      3'b001: alu_res = A & B;
      3'b010: alu_res = ~A;
      3'b011: alu_res = A;
      3'b100: begin
        alu_res = diff;
        alu_c   = (A >= B);
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      3'b101: alu_res = A | B;
      3'b110: alu_res = A ^ B;
      3'b111: alu_res = '0;
    endcase
  end

  always_comb begin
    state_n  = state;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    cnt_n    = cnt;
    out_n    = Out;
    c_n      = C;
    v_n      = V;
    valid_n  = Out_Valid & ~Out_Ready;
    case (state)
      IDLE: begin
        if (accept) begin
          if (Fn == 3'b111) begin
            state_n  = BUSY;
            mcand_n  = A;
            mplier_n = B;
            acc_n    = '0;
            cnt_n    = '0;
          end else begin
            out_n   = alu_res;
            c_n     = alu_c;
            v_n     = alu_v;
            valid_n = 1'b1;
          end
        end
      end
      BUSY: begin
        // WIDTH iteration edges, then one more edge to publish the product
        if (cnt == CW'(WIDTH)) begin
          out_n   = acc;
          c_n     = 1'b0;
          v_n     = 1'b0;
          valid_n = 1'b1;
          state_n = IDLE;
        end else begin
          if (mplier[0]) acc_n = acc + mcand;
          mcand_n  = mcand << 1;
          mplier_n = mplier >> 1;
          cnt_n    = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (out_n[WIDTH-1])   nzp_n = 3'b100;
    else if (out_n == '0) nzp_n = 3'b010;
    else                  nzp_n = 3'b001;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      Out       <= '0;
      NZP       <= 3'b010;
      C         <= 1'b0;
      V         <= 1'b0;
      Out_Valid <= 1'b0;
    end else begin
      state     <= state_n;
      mcand     <= mcand_n;
      mplier    <= mplier_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      Out       <= out_n;
      NZP       <= nzp_n;
      C         <= c_n;
      V         <= v_n;
      Out_Valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: stimulus pushes expected {Out,NZP,C,V} into a queue,
// a monitor pops and compares on every output handshake.
module tb_seq_alu;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic [2:0]  Fn = 3'b000;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [15:0] Out;
  logic        Out_Valid;
  logic        Out_Ready = 1'b1;
  logic [2:0]  NZP;
  logic        C;
  logic        V;

  int n_chk  = 0;
  int n_fail = 0;

  logic [20:0] exp_q[$];
  string       name_q[$];

  seq_alu #(.WIDTH(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Fn(Fn), .A(A), .B(B), .Out(Out), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .NZP(NZP), .C(C), .V(V)
  );

  always #5 Clk = ~Clk;

  function automatic logic [20:0] ex(logic [15:0] o, logic [2:0] nzp, logic c, logic v);
    return {o, nzp, c, v};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  // monitor: every consumed result must match the oldest outstanding expectation
  initial begin
    logic [20:0] e;
    string nm;
    forever begin
      @(negedge Clk);
      if (Reset_n && Out_Valid && Out_Ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got Out=%h NZP=%b C=%b V=%b, expected no result", Out, NZP, C, V);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if ({Out, NZP, C, V} !== e)
            begin
              n_fail++;
              $display("FAIL %s: got Out=%h NZP=%b C=%b V=%b, expected Out=%h NZP=%b C=%b V=%b",
                       nm, Out, NZP, C, V, e[20:5], e[4:2], e[1], e[0]);
            end
        end
      end
    end
  end

  // call at posedge+1; returns at posedge+1 just after the accept edge
  task automatic send(string nm, logic [2:0] f, logic [15:0] a, logic [15:0] b,
                      logic [20:0] e, bit push);
    bit ok;
    ok = 0;
    In_Valid = 1'b1; Fn = f; A = a; B = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge Clk);
      if (In_Ready) ok = 1;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL %s_accept_timeout: got In_Ready=0, expected 1", nm);
    end else if (push) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    @(posedge Clk); #1;
    In_Valid = 1'b0;
    if (ok && f != 3'b111) chk({nm, "_latency"}, 32'(Out_Valid), 32'd1);
  endtask

  task automatic mul_timed(string nm, logic [15:0] a, logic [15:0] b, logic [20:0] e);
    int hit;
    bit rdy_seen;
    hit = -1;
    rdy_seen = 0;
    send(nm, 3'b111, a, b, e, 1);
    for (int k = 1; k <= 40; k++) begin
      if (In_Ready) rdy_seen = 1;
      @(posedge Clk); #1;
      if (Out_Valid) begin
        hit = k;
        break;
      end
    end
    chk({nm, "_edges_to_valid"}, 32'(hit), 32'd17);
    chk({nm, "_in_ready_low_busy"}, 32'(rdy_seen), 32'd0);
  endtask

  initial begin
    bit bad;
    // reset held two cycles
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("rst_in_ready", 32'(In_Ready), 32'd0);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("rst_out", 32'(Out), 32'h0000);
    chk("rst_nzp", 32'(NZP), 32'b010);
    chk("rst_out_valid", 32'(Out_Valid), 32'd0);
    chk("rst_cv", 32'({C, V}), 32'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("rst_release_in_ready", 32'(In_Ready), 32'd1);
    @(posedge Clk); #1;

    send("add_ovf",   3'b000, 16'h7FF0, 16'h0010, ex(16'h8000, 3'b100, 1'b0, 1'b1), 1);
    send("add_carry", 3'b000, 16'hFFFF, 16'h0001, ex(16'h0000, 3'b010, 1'b1, 1'b0), 1);

    // back-to-back: Out_Valid must remain high across the pair
    send("sub_neg",   3'b100, 16'h0005, 16'h0006, ex(16'hFFFF, 3'b100, 1'b0, 1'b0), 1);
    send("and_b2b",   3'b001, 16'hCAFE, 16'hFF00, ex(16'hCA00, 3'b100, 1'b0, 1'b0), 1);
    @(negedge Clk);
    chk("and_b2b_out", 32'(Out), 32'h0000CA00);
    @(posedge Clk); #1;

    send("sub_ovf", 3'b100, 16'h8000, 16'h0001, ex(16'h7FFF, 3'b001, 1'b1, 1'b1), 1);
    send("or",      3'b101, 16'h00F0, 16'h0F00, ex(16'h0FF0, 3'b001, 1'b0, 1'b0), 1);
    send("xor_zero",3'b110, 16'hAAAA, 16'hAAAA, ex(16'h0000, 3'b010, 1'b0, 1'b0), 1);

    mul_timed("mul_basic", 16'h0123, 16'h0010, ex(16'h1230, 3'b001, 1'b0, 1'b0));
    mul_timed("mul_wrap",  16'h0100, 16'h0100, ex(16'h0000, 3'b010, 1'b0, 1'b0));
    mul_timed("mul_neg",   16'hFFFF, 16'h0002, ex(16'hFFFE, 3'b100, 1'b0, 1'b0));

    // stall: result must hold while Out_Ready=0, new request must wait
    repeat (2) @(posedge Clk); #1;
    Out_Ready = 1'b0;
    send("passa", 3'b011, 16'hF00D, 16'h1234, ex(16'hF00D, 3'b100, 1'b0, 1'b0), 1);
    In_Valid = 1'b1; Fn = 3'b010; A = 16'hECEB; B = 16'h0000;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (Out !== 16'hF00D || NZP !== 3'b100 || In_Ready !== 1'b0 || Out_Valid !== 1'b1) bad = 1;
      @(posedge Clk); #1;
    end
    chk("stall_hold", 32'(bad), 32'd0);
    Out_Ready = 1'b1;
    send("not", 3'b010, 16'hECEB, 16'h0000, ex(16'h1314, 3'b001, 1'b0, 1'b0), 1);

    // reset aborts a MUL in flight
    repeat (2) @(posedge Clk); #1;
    send("mul_abort", 3'b111, 16'h0003, 16'h0005, '0, 0);
    repeat (4) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("abort_in_ready", 32'(In_Ready), 32'd0);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("abort_out", 32'(Out), 32'h0000);
    chk("abort_nzp", 32'(NZP), 32'b010);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge Clk); #1;
      if (Out_Valid) bad = 1;
    end
    chk("abort_no_valid", 32'(bad), 32'd0);
    send("add_after_abort", 3'b000, 16'd100, 16'd55, ex(16'h009B, 3'b001, 1'b0, 1'b0), 1);

    begin
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 200) begin
        @(posedge Clk);
        w++;
      end
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    end
    repeat (3) @(posedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
